vector_load_gather: RTL and testbench
=====================================

Name: vector_load_gather

Overview:
- MEM-stage vector load unit and the read-side counterpart of the EX-stage fork/join datapath.
- Fetches a V-element vector from data memory LANES words per cycle, starting at a scalar base address.
- Assembles the words into one V×N vector and pulses ready_o once the vector is complete.
- ready_o drives the MEM-stage pipe enable. This is the same role the fork ready signal plays for EX_MEM.

Parameters:
- N, 32, element/word width in bits
- V, 20, elements per vector
- LANES, 4, words returned by the memory read port per cycle
- CHUNKS, ceil(V/LANES) (derived, localparam), read beats per vector

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- start_i  in  1  request a vector load; sampled only in IDLE or DONE
- base_addr_i  in  N  word address of element 0; sampled with start_i
- mem_re_o  out  1  memory read enable
- mem_addr_o  out  N  word address of the first lane of the current beat
- mem_rdata_i  in  LANES*N  read data; lane k = word mem_addr+k; valid exactly 1 cycle after mem_re_o
- vector_o  out  V*N  assembled vector, element i in bits [i*N +: N]
- ready_o  out  1  one-cycle pulse: vector_o complete
- busy_o  out  1  high in LOAD and DRAIN

Behaviour:
- All state is registered; reset and every transition happen on posedge CLK.
- RST (takes priority over everything, including mid-load):
  - state=IDLE, issue_cnt=0, cap_cnt=0, vector_o=0, ready_o=0, mem_re_o=0, mem_addr_o=0, busy_o=0.
  - Any in-flight read data is discarded.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - start_i=1 → latch base_addr_i, issue_cnt=0, next state LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - Outputs: mem_re_o=1, mem_addr_o = base + issue_cnt*LANES, truncated mod 2^N (wraps).
  - issue_cnt increments every cycle.
  - When issue_cnt==CHUNKS-1 → next state DRAIN.
- Capture:
  - In the cycle after each issue, mem_rdata_i lanes are written into vector_o elements cap_cnt*LANES+k for k=0..LANES-1; then cap_cnt increments.
  - Lanes with index ≥ V (partial last beat) are discarded.
  - Elements outside the beat being captured keep their value.
- DRAIN: mem_re_o=0, busy_o=1. Captures the last beat, then next state DONE.
- DONE:
  - ready_o=1 for this single cycle.
  - start_i=1 here → latch new base and go directly to LOAD (back-to-back, no IDLE bubble). Otherwise → IDLE.
- Latency: start_i accepted in cycle t → ready_o high in cycle t+CHUNKS+2 (cycle t+7 for defaults).
- vector_o holds its value from DONE until the first capture of the next load.
- start_i in LOAD or DRAIN: ignored, no queueing.
- base_addr_i is ignored except in the cycle start_i is accepted.

Decomposition:
- Package vec_pkg holds:
  - the state enum (IDLE, LOAD, DRAIN, DONE);
  - LANES default;
  - a function chunks(V, LANES) returning the ceiling division;
  - the shared typedef for a V×N vector (packed [V-1:0][N-1:0]), also used by the fork/join blocks.
- One sub-module, lane_chunk_insert: purely combinational. Takes the current vector, a chunk index and a LANES*N beat; returns the updated vector and masks lanes ≥ V.

Test Plan:
- Basic load: V=20, LANES=4, memory word[a]=3a, base=0x100, start_i pulsed in cycle 0.
  - mem_addr_o = 0x100, 0x104, 0x108, 0x10C, 0x110 in cycles 1–5.
  - ready_o high in cycle 7 only.
  - vector_o[i] = 3*(0x100+i) for i=0..19.
- Partial last beat: V=18.
  - 5 beats issued.
  - vector_o[16]=3*(base+16), vector_o[17]=3*(base+17); lanes 2–3 of the last beat are dropped.
  - No out-of-range write.
- Address wrap: N=32, base=0xFFFFFFFC.
  - mem_addr_o = 0xFFFFFFFC, 0x00000000, 0x00000004, …
  - Data assembled in issue order.
- Reset mid-operation: assert RST during the third LOAD cycle.
  - Next cycle: mem_re_o=0, ready_o=0, busy_o=0, vector_o=0, state IDLE.
  - A new start with base=0x40 completes normally in 7 cycles.
- Ignored and back-to-back starts:
  - start_i held high through LOAD: no restart, and ready_o pulses once at cycle 7.
  - start_i=1 in the DONE cycle with base=0x200: LOAD begins the next cycle and the second ready_o arrives 7 cycles after the first.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared types and helpers for the vector datapath: FSM states, default sizes
// and the V x N vector typedef used by the load gather and fork/join blocks.
package vec_pkg;

  localparam int N_DEFAULT     = 32;
  localparam int V_DEFAULT     = 20;
  localparam int LANES_DEFAULT = 4;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  typedef logic [V_DEFAULT-1:0][N_DEFAULT-1:0] vec_t;

  function automatic int chunks(input int v, input int lanes);
    return (v + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/lane_chunk_insert.sv
// Combinational merge of one memory beat (LANES words) into a V-element vector
// at chunk position `chunk`; lanes that would land past element V-1 are dropped.
module lane_chunk_insert #(
  parameter int N     = 32,
  parameter int V     = 20,
  parameter int LANES = 4,
  parameter int CW    = 3
) (
  input  logic [V-1:0][N-1:0]   vec_in,
  input  logic [CW-1:0]         chunk,
  input  logic [LANES*N-1:0]    beat,
  output logic [V-1:0][N-1:0]   vec_out
);

  // Walking the destination elements (not the lanes) means a partial last
  // beat simply has no element to write its upper lanes into.
  always_comb begin
    vec_out = vec_in;
    for (int e = 0; e < V; e++) begin
      if (int'(chunk) == (e / LANES)) begin
        vec_out[e] = beat[(e % LANES)*N +: N];
      end
    end
  end

endmodule

// File: rtl/vector_load_gather.sv
// MEM-stage vector load: reads V words LANES at a time from base_addr_i,
// assembles them into vector_o and pulses ready_o when the vector is complete.
module vector_load_gather
  import vec_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int V     = V_DEFAULT,
  parameter int LANES = LANES_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start_i,
  input  logic [N-1:0]         base_addr_i,
  output logic                 mem_re_o,
  output logic [N-1:0]         mem_addr_o,
  input  logic [LANES*N-1:0]   mem_rdata_i,
  output logic [V-1:0][N-1:0]  vector_o,
  output logic                 ready_o,
  output logic                 busy_o
);

  localparam int CHUNKS = chunks(V, LANES);
  localparam int CNT_W  = $clog2(CHUNKS + 1);

  state_t                state;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      cap_cnt;
  logic                  cap_valid;
  logic [V-1:0][N-1:0]   vec_next;

  lane_chunk_insert #(
    .N     (N),
    .V     (V),
    .LANES (LANES),
    .CW    (CNT_W)
  ) u_insert (
    .vec_in  (vector_o),
    .chunk   (cap_cnt),
    .beat    (mem_rdata_i),
    .vec_out (vec_next)
  );

  // Read data trails each issue by one cycle, so cap_valid is mem_re_o delayed;
  // the address advances incrementally, equal to base + issue_cnt*LANES mod 2^N.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      cap_cnt    <= '0;
      cap_valid  <= 1'b0;
      vector_o   <= '0;
      ready_o    <= 1'b0;
      mem_re_o   <= 1'b0;
      mem_addr_o <= '0;
      busy_o     <= 1'b0;
    end else begin
      ready_o   <= 1'b0;
      cap_valid <= mem_re_o;

      if (cap_valid) begin
        vector_o <= vec_next;
        cap_cnt  <= cap_cnt + CNT_W'(1);
      end

      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state      <= LOAD;
            issue_cnt  <= '0;
            cap_cnt    <= '0;
            mem_re_o   <= 1'b1;
            mem_addr_o <= base_addr_i;
            busy_o     <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          issue_cnt <= issue_cnt + CNT_W'(1);
          if (issue_cnt == CNT_W'(CHUNKS - 1)) begin
            state    <= DRAIN;
            mem_re_o <= 1'b0;
          end else begin
            mem_addr_o <= mem_addr_o + N'(LANES);
          end
        end
        DRAIN: begin
          state   <= DONE;
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_load_gather.sv
// Directed bench for vector_load_gather: a V=20 and a V=18 instance share stimulus;
// a scoreboard of expected addresses and vectors is checked as the DUTs produce them.
module tb_vector_load_gather;

  localparam int N  = 32;
  localparam int VA = 20;
  localparam int VB = 18;
  localparam int L  = 4;

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } addr_item_t;

  typedef struct {
    logic [639:0] vec;
    int           cyc;
  } vec_item_t;

  logic                CLK = 1'b0;
  logic                RST;
  logic                start_i;
  logic [N-1:0]        base_addr_i;

  logic                re_a, ready_a, busy_a;
  logic [N-1:0]        addr_a;
  logic [L*N-1:0]      rdata_a;
  logic [VA-1:0][N-1:0] vec_a;

  logic                re_b, ready_b, busy_b;
  logic [N-1:0]        addr_b;
  logic [L*N-1:0]      rdata_b;
  logic [VB-1:0][N-1:0] vec_b;

  int cyc = 0;
  int tests = 0;
  int failed = 0;

  addr_item_t addr_q[$];
  vec_item_t  vec_a_q[$];
  logic [639:0] vec_b_q[$];

  vector_load_gather #(.N(N), .V(VA), .LANES(L)) u_dut_a (
    .CLK(CLK), .RST(RST), .start_i(start_i), .base_addr_i(base_addr_i),
    .mem_re_o(re_a), .mem_addr_o(addr_a), .mem_rdata_i(rdata_a),
    .vector_o(vec_a), .ready_o(ready_a), .busy_o(busy_a)
  );

  vector_load_gather #(.N(N), .V(VB), .LANES(L)) u_dut_b (
    .CLK(CLK), .RST(RST), .start_i(start_i), .base_addr_i(base_addr_i),
    .mem_re_o(re_b), .mem_addr_o(addr_b), .mem_rdata_i(rdata_b),
    .vector_o(vec_b), .ready_o(ready_b), .busy_o(busy_b)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Memory model: word[a] = 3a, one-cycle read latency, junk when not reading.
  always @(posedge CLK) begin
    for (int k = 0; k < L; k++) begin
      rdata_a[k*N +: N] <= re_a ? (addr_a + 32'(k)) * 32'd3 : 32'hDEADBEEF;
      rdata_b[k*N +: N] <= re_b ? (addr_b + 32'(k)) * 32'd3 : 32'hDEADBEEF;
    end
  end

  function automatic logic [639:0] exp_vec(input logic [31:0] base, input int v);
    logic [639:0] r;
    r = '0;
    for (int i = 0; i < v; i++) r[i*32 +: 32] = (base + 32'(i)) * 32'd3;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drives start_i for `hold` cycles from the current cycle and queues the
  // addresses and vectors the load accepted in this cycle must produce.
  task automatic applyStimulus(input logic [31:0] base, input int hold);
    int t0;
    t0 = cyc;
    start_i = 1'b1;
    base_addr_i = base;
    for (int j = 0; j < 5; j++) addr_q.push_back('{base + 32'(j*L), t0 + 1 + j});
    vec_a_q.push_back('{exp_vec(base, VA), t0 + 7});
    vec_b_q.push_back(exp_vec(base, VB));
    for (int h = 0; h < hold; h++) begin
      waitCycles(1);
      base_addr_i = 32'hDEAD0000;
    end
    start_i = 1'b0;
  endtask

  task automatic waitDrained();
    int n;
    n = 0;
    while ((addr_q.size() + vec_a_q.size() + vec_b_q.size()) != 0 && n < 40) begin
      waitCycles(1);
      n++;
    end
    checkOutput("drain_timeout", 640'(addr_q.size() + vec_a_q.size() + vec_b_q.size()), 640'(0));
  endtask

  always @(negedge CLK) begin : monitor
    addr_item_t a;
    vec_item_t  va;
    logic [639:0] vb;
    if (!RST) begin
      if (re_a) begin
        checkOutput("read_expected", 640'(addr_q.size() != 0), 640'(1));
        if (addr_q.size() != 0) begin
          a = addr_q.pop_front();
          checkOutput("mem_addr", 640'(addr_a), 640'(a.addr));
          checkOutput("mem_addr_cycle", 640'(cyc), 640'(a.cyc));
          checkOutput("mem_addr_v18", 640'(addr_b), 640'(a.addr));
        end
      end
      if (ready_a) begin
        checkOutput("ready_expected", 640'(vec_a_q.size() != 0), 640'(1));
        checkOutput("ready_v18", 640'(ready_b), 640'(1));
        if (vec_a_q.size() != 0) begin
          va = vec_a_q.pop_front();
          checkOutput("vector_v20", 640'(vec_a), va.vec);
          checkOutput("ready_cycle", 640'(cyc), 640'(va.cyc));
        end
        if (vec_b_q.size() != 0) begin
          vb = vec_b_q.pop_front();
          checkOutput("vector_v18", 640'(vec_b), vb);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST = 1'b1;
    start_i = 1'b0;
    base_addr_i = '0;
    waitCycles(3);

    checkOutput("reset_re", 640'(re_a), 640'(0));
    checkOutput("reset_addr", 640'(addr_a), 640'(0));
    checkOutput("reset_ready", 640'(ready_a), 640'(0));
    checkOutput("reset_busy", 640'(busy_a), 640'(0));
    checkOutput("reset_vector", 640'(vec_a), 640'(0));

    RST = 1'b0;
    waitCycles(1);

    // Basic load plus hold of vector_o after DONE.
    applyStimulus(32'h100, 1);
    checkOutput("busy_in_load", 640'(busy_a), 640'(1));
    waitDrained();
    waitCycles(2);
    checkOutput("hold_v20", 640'(vec_a), exp_vec(32'h100, VA));
    checkOutput("hold_v18", 640'(vec_b), exp_vec(32'h100, VB));
    checkOutput("idle_busy", 640'(busy_a), 640'(0));

    // Address wrap.
    applyStimulus(32'hFFFFFFFC, 1);
    waitDrained();
    waitCycles(2);

    // Reset in the third LOAD cycle.
    applyStimulus(32'h80, 1);
    waitCycles(2);
    RST = 1'b1;
    waitCycles(1);
    RST = 1'b0;
    addr_q.delete();
    vec_a_q.delete();
    vec_b_q.delete();
    checkOutput("rst_mid_re", 640'(re_a), 640'(0));
    checkOutput("rst_mid_ready", 640'(ready_a), 640'(0));
    checkOutput("rst_mid_busy", 640'(busy_a), 640'(0));
    checkOutput("rst_mid_vector", 640'(vec_a), 640'(0));
    waitCycles(1);
    checkOutput("rst_mid_vector_later", 640'(vec_a), 640'(0));
    applyStimulus(32'h40, 1);
    waitDrained();
    waitCycles(2);

    // start_i held through LOAD with a changing base: no restart, one ready.
    applyStimulus(32'h300, 6);
    waitDrained();
    waitCycles(3);
    checkOutput("no_restart_busy", 640'(busy_a), 640'(0));

    // Back-to-back: second start in the DONE cycle.
    applyStimulus(32'h100, 1);
    waitCycles(6);
    checkOutput("b2b_done_ready", 640'(ready_a), 640'(1));
    applyStimulus(32'h200, 1);
    checkOutput("b2b_hold_vector", 640'(vec_a), exp_vec(32'h100, VA));
    waitDrained();
    waitCycles(3);
    checkOutput("final_empty", 640'(addr_q.size() + vec_a_q.size()), 640'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
